// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider and its reference models.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;

  localparam int DIV_WIDTH = 8;

  // Magnitude of a sign-extended operand; callers truncate to their width, so
  // the most-negative WIDTH-bit value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [63:0] mag64(input logic signed [63:0] v);
    return v[63] ? 64'(-v) : 64'(v);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift, trial subtract, pick quotient bit.
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] dq_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           qbit;

  assign shifted  = {rem[WIDTH-1:0], dq[WIDTH-1]};
  // Partial remainder stays below 2^WIDTH, so the top bit of diff is the borrow.
  assign diff     = shifted - {1'b0, dvs};
  assign qbit     = ~diff[WIDTH];
  assign rem_next = qbit ? diff : shifted;
  assign dq_next  = {dq[WIDTH-2:0], qbit};

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: WIDTH restoring steps on magnitudes, then sign fix-up.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH-1:0] dq, dq_next;
  logic [WIDTH-1:0] dvs_mag, dvd_raw;
  logic             neg_q, neg_r, dz, ov;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
  logic             accept;

  assign dvd_abs = WIDTH'(mag64(64'(signed'(dividend))));
  assign dvs_abs = WIDTH'(mag64(64'(signed'(divisor))));
  assign accept  = (state == IDLE) && start;
  assign busy    = (state != IDLE);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dq       (dq),
    .dvs      (dvs_mag),
    .rem_next (rem_next),
    .dq_next  (dq_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      dq      <= '0;
      dvs_mag <= '0;
      dvd_raw <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      ov      <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(WIDTH - 1);
      rem     <= '0;
      dq      <= dvd_abs;
      dvs_mag <= dvs_abs;
      dvd_raw <= dividend;
      neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r   <= dividend[WIDTH-1];
      dz      <= (divisor == '0);
      ov      <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end else if (state == CALC) begin
      rem <= rem_next;
      dq  <= dq_next;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // The overflow case needs no override: |q| = 2^(WIDTH-1) wraps to itself.
  always_comb begin
    q_fix = neg_q ? -dq : dq;
    r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (dz) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= dz;
        overflow    <= ov;
      end
    end
  end

endmodule
